// File: rtl/seg_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment display.
// Glyphs are active-low: [6:0] = CG..CA, [7] = DP (kept off here).
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    localparam seg_t SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment pattern decode.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Round-robin hex display scanner with ghost blanking, per-digit mask/DP
// and leading-zero suppression; all pin outputs are registered.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int DATA_W      = 32,
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              value_valid,
    input  logic              hold,
    input  logic              lz_en,
    input  logic [DIGITS-1:0] blank_mask,
    input  logic [DIGITS-1:0] dp,
    output logic [DIGITS-1:0] AN,
    output logic [7:0]        CT,
    output logic [DATA_W-1:0] shown
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB_W = 4 * DIGITS;

    logic [DATA_W-1:0] shown_q, shown_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    seg_t              ct_q, ct_d;

    logic [NIB_W-1:0]  padded;
    logic [3:0]        nib [DIGITS];
    logic [3:0]        cur_nib;
    logic [IDX_W-1:0]  msd;
    seg_t              glyph;
    logic              tick;
    logic              ghost;
    logic              suppress;

    // Nibbles above DATA_W read as zero.
    always_comb begin
        padded = '0;
        padded[DATA_W-1:0] = shown_q;
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = padded[4*i +: 4];
        end
    end

    // Highest non-zero nibble wins; an all-zero word leaves msd at 0.
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (nib[i] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
    end

    assign cur_nib  = nib[idx_q];
    assign suppress = lz_en && (idx_q > msd);
    assign tick     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign ghost    = (cnt_q < CNT_W'(GHOST_CYC));

    hex_to_seg u_hex (
        .nibble (cur_nib),
        .seg    (glyph)
    );

    always_comb begin
        shown_d = shown_q;
        if (value_valid && !hold) begin
            shown_d = value;
        end

        cnt_d = tick ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        an_d = '1;
        ct_d = SEG_OFF;
        if (!ghost) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (blank_mask[idx_q]) begin
                ct_d = SEG_OFF;
            end else if (suppress) begin
                ct_d = {~dp[idx_q], 7'h7F};
            end else begin
                ct_d = {glyph[7] & ~dp[idx_q], glyph[6:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shown_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            ct_q    <= SEG_OFF;
        end else begin
            shown_q <= shown_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            ct_q    <= ct_d;
        end
    end

    assign AN    = an_q;
    assign CT    = ct_q;
    assign shown = shown_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (DIGITS=8, REFRESH_DIV=4, GHOST_CYC=1).
// A cycle model pushes expected outputs at each edge; scenario tasks pop and compare.
module tb_seg_scan_display;

    typedef struct packed {
        logic [7:0]  an;
        logic [7:0]  ct;
        logic [31:0] shown;
    } exp_t;

    localparam logic [6:0] GL7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic        value_valid = 1'b0;
    logic        hold = 1'b0;
    logic        lz_en = 1'b0;
    logic [7:0]  blank_mask = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  AN;
    logic [7:0]  CT;
    logic [31:0] shown;

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_cnt = '0;
    logic [2:0]  m_idx = '0;
    logic [31:0] m_shown = '0;
    exp_t        sb [$];

    seg_scan_display #(
        .DIGITS      (8),
        .DATA_W      (32),
        .REFRESH_DIV (4),
        .GHOST_CYC   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .hold        (hold),
        .lz_en       (lz_en),
        .blank_mask  (blank_mask),
        .dp          (dp),
        .AN          (AN),
        .CT          (CT),
        .shown       (shown)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] c, input logic [2:0] i,
                                   input logic [31:0] s, input logic lz,
                                   input logic [7:0] bm, input logic [7:0] dpv,
                                   input logic [31:0] nv);
        exp_t r;
        logic [3:0] n;
        int top;
        r.an = 8'hFF;
        r.ct = 8'hFF;
        r.shown = nv;
        if (c != 2'd0) begin
            r.an = 8'hFF ^ (8'h01 << i);
            n = 4'((s >> (4 * i)) & 32'hF);
            top = 0;
            for (int j = 7; j >= 0; j--) begin
                if (top == 0 && ((s >> (4 * j)) & 32'hF) != 0) top = j;
            end
            if (bm[i]) r.ct = 8'hFF;
            else if (lz && int'(i) > top) r.ct = {~dpv[i], 7'h7F};
            else r.ct = {~dpv[i], GL7[n]};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sb.push_back('{an: 8'hFF, ct: 8'hFF, shown: 32'h0});
            m_cnt   <= '0;
            m_idx   <= '0;
            m_shown <= '0;
        end else begin
            sb.push_back(model(m_cnt, m_idx, m_shown, lz_en, blank_mask, dp,
                               (value_valid && !hold) ? value : m_shown));
            if (value_valid && !hold) m_shown <= value;
            m_cnt <= m_cnt + 2'd1;
            if (m_cnt == 2'd3) m_idx <= m_idx + 3'd1;
        end
    end

    task automatic step(output exp_t e);
        @(posedge clk);
        #1;
        if (sb.size() != 0) e = sb.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            step(e);
            checks++;
            if (AN !== 8'hFF || CT !== 8'hFF || shown !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold an=%h ct=%h shown=%h want FF FF 0", AN, CT, shown);
            end
        end
        rst = 1'b0;
        step(e);
        checks++;
        if (AN !== 8'hFF || CT !== 8'hFF) begin
            errors++;
            $display("FAIL reset_ghost an=%h ct=%h want FF FF", AN, CT);
        end
        step(e);
        checks++;
        if (AN !== 8'hFE || CT !== 8'hC0) begin
            errors++;
            $display("FAIL reset_first_lit an=%h ct=%h want FE C0", AN, CT);
        end
        checks++;
        if (AN !== e.an || CT !== e.ct || shown !== e.shown) begin
            errors++;
            $display("FAIL reset_sb an=%h/%h ct=%h/%h", AN, e.an, CT, e.ct);
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int ghosts;
        int prev;
        logic [7:0] seen;
        logic [7:0] want [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6,
                                 8'h83, 8'h88, 8'h90, 8'h80};
        value = 32'h89ABCDEF;
        value_valid = 1'b1;
        step(e);
        value_valid = 1'b0;
        checks++;
        if (shown !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL scan_capture shown=%h want 89ABCDEF", shown);
        end
        step(e);
        ghosts = 0;
        seen = '0;
        prev = -1;
        for (int c = 0; c < 32; c++) begin
            step(e);
            checks++;
            if (AN !== e.an || CT !== e.ct || shown !== e.shown) begin
                errors++;
                $display("FAIL scan_sb an=%h/%h ct=%h/%h", AN, e.an, CT, e.ct);
            end
            if (AN == 8'hFF) ghosts++;
            for (int k = 0; k < 8; k++) begin
                if (AN[k] == 1'b0) begin
                    seen[k] = 1'b1;
                    checks++;
                    if (CT !== want[k]) begin
                        errors++;
                        $display("FAIL scan_glyph d%0d ct=%h want %h", k, CT, want[k]);
                    end
                    if (prev >= 0 && k != prev && k != (prev + 1) % 8) begin
                        errors++;
                        $display("FAIL scan_order d%0d after d%0d", k, prev);
                    end
                    prev = k;
                end
            end
        end
        checks++;
        if (ghosts != 8) begin
            errors++;
            $display("FAIL scan_ghosts got %0d want 8", ghosts);
        end
        checks++;
        if (seen !== 8'hFF) begin
            errors++;
            $display("FAIL scan_coverage seen=%h want FF", seen);
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        value = 32'h1234;
        value_valid = 1'b1;
        hold = 1'b1;
        step(e);
        checks++;
        if (shown !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL hold_wins shown=%h want 89ABCDEF", shown);
        end
        hold = 1'b0;
        step(e);
        value_valid = 1'b0;
        checks++;
        if (shown !== 32'h1234) begin
            errors++;
            $display("FAIL capture shown=%h want 00001234", shown);
        end
        for (int c = 0; c < 9; c++) begin
            step(e);
            checks++;
            if (AN !== e.an || CT !== e.ct || shown !== e.shown) begin
                errors++;
                $display("FAIL hs_sb an=%h/%h ct=%h/%h shown=%h/%h",
                         AN, e.an, CT, e.ct, shown, e.shown);
            end
        end
    endtask

    task automatic test_leading_zero();
        exp_t e;
        logic [31:0] vals [2] = '{32'h00000A05, 32'h0};
        logic [7:0] want [2][8] = '{
            '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
            '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        lz_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            value = vals[p];
            value_valid = 1'b1;
            step(e);
            value_valid = 1'b0;
            step(e);
            for (int c = 0; c < 32; c++) begin
                step(e);
                checks++;
                if (AN !== e.an || CT !== e.ct || shown !== e.shown) begin
                    errors++;
                    $display("FAIL lz_sb an=%h/%h ct=%h/%h", AN, e.an, CT, e.ct);
                end
                for (int k = 0; k < 8; k++) begin
                    if (AN[k] == 1'b0) begin
                        checks++;
                        if (CT !== want[p][k]) begin
                            errors++;
                            $display("FAIL lz_p%0d d%0d ct=%h want %h", p, k, CT, want[p][k]);
                        end
                    end
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_mask_dp();
        exp_t e;
        logic [7:0] want [8] = '{8'h40, 8'hFF, 8'hC0, 8'hC0,
                                 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        blank_mask = 8'h02;
        dp = 8'h01;
        for (int c = 0; c < 32; c++) begin
            step(e);
            checks++;
            if (AN !== e.an || CT !== e.ct) begin
                errors++;
                $display("FAIL mask_sb an=%h/%h ct=%h/%h", AN, e.an, CT, e.ct);
            end
            for (int k = 0; k < 8; k++) begin
                if (AN[k] == 1'b0) begin
                    checks++;
                    if (CT !== want[k]) begin
                        errors++;
                        $display("FAIL mask_dp d%0d ct=%h want %h", k, CT, want[k]);
                    end
                end
            end
        end
        blank_mask = '0;
        dp = '0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit found;
        value = 32'hDEAD;
        value_valid = 1'b1;
        step(e);
        value_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            step(e);
            if (m_idx == 3'd5 && m_cnt == 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_sync idx=5 cnt=2 never reached");
        end
        rst = 1'b1;
        step(e);
        rst = 1'b0;
        checks++;
        if (AN !== 8'hFF || CT !== 8'hFF || shown !== 32'h0) begin
            errors++;
            $display("FAIL midrst an=%h ct=%h shown=%h want FF FF 0", AN, CT, shown);
        end
        step(e);
        checks++;
        if (AN !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_ghost an=%h want FF", AN);
        end
        step(e);
        checks++;
        if (AN !== 8'hFE || CT !== 8'hC0) begin
            errors++;
            $display("FAIL midrst_resume an=%h ct=%h want FE C0", AN, CT);
        end
        for (int c = 0; c < 6; c++) begin
            step(e);
            checks++;
            if (AN !== e.an || CT !== e.ct || shown !== e.shown) begin
                errors++;
                $display("FAIL midrst_sb an=%h/%h ct=%h/%h", AN, e.an, CT, e.ct);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_handshake();
        test_leading_zero();
        test_mask_dp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment driver. It latches a result word from the CPU, such as the writeback result, under a valid/hold handshake, and shows it as hexadecimal across `DIGITS` common-anode digits. Digits are scanned round-robin with a programmable refresh divider, an anti-ghosting blank window, per-digit blanking and decimal points, and optional leading-zero suppression. It sits at the top level between the CPU result bus and the board `AN`/`CT` pins, and supersedes the fixed 8-digit display.

## Interface
- `DIGITS`, default 8: number of digits scanned (1..8).
- `DATA_W`, default 32: width of `value`; must satisfy `DATA_W <= 4*DIGITS`.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (>= 2).
- `GHOST_CYC`, default 4: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `value` input `DATA_W`: word to display.
- `value_valid` input 1: capture `value` this cycle.
- `hold` input 1: freeze the latched word; overrides `value_valid`.
- `lz_en` input 1: enable leading-zero suppression.
- `blank_mask` input `DIGITS`: bit i=1 forces digit i dark.
- `dp` input `DIGITS`: bit i=1 lights the decimal point of digit i.
- `AN` output `DIGITS`: anodes, active-low, bit i = digit i.
- `CT` output 8: cathodes, active-low; [6:0]=CG..CA, [7]=DP.
- `shown` output `DATA_W`: currently latched word, for debug.

## Operation
- Latch: at an edge with `value_valid=1` and `hold=0`, `shown <= value`. Otherwise `shown` is unchanged. When `value_valid` and `hold` are both 1, hold wins and the word is not captured.
- Nibble map: digit i shows `shown[4i+3:4i]`. Nibbles beyond `DATA_W` read as 0.
- Slot counter `cnt`: 0..`REFRESH_DIV`-1, wraps. A tick occurs when `cnt = REFRESH_DIV-1`.
- Digit index `idx`: advances on each tick, and wraps from `DIGITS-1` to 0.
- Ghost window: while `cnt < GHOST_CYC`, the next `AN` is all ones and the next `CT` is 8'hFF.
- Lit phase: the next `AN` has only bit `idx` low. The next `CT` is the segment pattern for nibble `idx`, with the DP bit set from `dp[idx]`.
- Blanking: if `blank_mask[idx]=1`, `AN` still selects the digit but `CT` is 8'hFF.
- Leading-zero suppression: with `lz_en=1`, a digit i > 0 is blanked (CT=8'hFF, DP still honoured) when every nibble at positions >= i is 0. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Segment patterns follow the standard hex glyph set 0-9, A, b, C, d, E, F.

## Timing
- All outputs are registered.
- Reset values:
  - `AN` all ones, `CT` 8'hFF.
  - `shown` 0, `cnt` 0, `idx` 0.
- Output latency: `AN`/`CT` after edge k reflect `cnt`/`idx`/`shown`/`lz_en`/`blank_mask`/`dp` as they were during cycle k-1, i.e. one cycle of latency.
- Capture to display: if capture happens at edge E, the new glyph appears on the active digit after edge E+1. Mid-slot updates are allowed and are not deferred to a slot boundary.
- Full scan period is `DIGITS*REFRESH_DIV` cycles. Each digit is lit for `REFRESH_DIV-GHOST_CYC` cycles per period.
- Reset asserted mid-slot: at the next edge, all state returns to reset values. The scan restarts at digit 0 with `cnt`=0, so it begins with a ghost window.
- `DIGITS=1`: `idx` stays 0, and the ghost window still applies every slot.

## Structure
- Package `seg_pkg` holds:
  - 16-entry active-low glyph constant array `SEG_HEX`, and constant `SEG_OFF = 8'hFF`.
  - `typedef logic [7:0] seg_t`.
- Sub-module `hex_to_seg`: combinational nibble → `seg_t` decode using `SEG_HEX`.
- The top level holds the latch register, slot counter, digit index, leading-zero detector and output registers.
- The leading-zero detector is a priority scan for the highest non-zero nibble, giving index `msd`. Digit i is suppressed iff i > `msd`.

## Test plan
Benches use `DIGITS=8`, `REFRESH_DIV=4`, `GHOST_CYC=1`.
- **Reset:** hold `rst=1` for 3 cycles → `AN=8'hFF`, `CT=8'hFF`, `shown=0`. After release, the first lit `AN=8'hFE` appears after edge 2 with `CT` = glyph "0" (8'hC0).
- **Scan order:** with `value=32'h89ABCDEF` captured, observe one full scan period of 32 cycles → `AN` walks FE,FD,…,7F. `CT` for digits 0..7 is F,E,d,C,b,A,9,8. There is one all-off cycle per slot.
- **Handshake:** `value_valid=1` with `hold=1` and value 32'h1234 → `shown` is unchanged. Then `hold=0` with `value_valid=1` → `shown=32'h1234` after one edge, and the active digit's `CT` is updated one edge later.
- **Leading zeros:** `lz_en=1`, `shown=32'h00000A05`:
  - digits 0..2 show 5, 0, A; digits 3..7 have `CT=8'hFF`.
  - With `shown=0`, only digit 0 shows "0".
- **Mask and DP:** `blank_mask=8'h02`, `dp=8'h01` → digit 1 has `CT=8'hFF`, and digit 0 has `CT[7]=0`.
- **Reset mid-scan:** assert `rst` while `idx=5`, `cnt=2` → next edge gives `AN=8'hFF` and `shown=0`. The scan resumes at digit 0.
